// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending transaction sequencer: command arbitration, totals, dispense/change FSM
// Define VEND_TIMEOUT_EN to build the SELECT inactivity refund timer.
module vend_sequencer #(
  parameter int DISPENSE_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter int MAX_TOTAL       = 99
) (
  input  logic       clock,
  input  logic       clr_n,
  input  logic       voice_valid,
  input  logic [2:0] voice_cmd,
  input  logic       ir_valid,
  input  logic [7:0] ir_cmd,
  input  logic [2:0] coin_pulse,
  output logic [6:0] item_total,
  output logic [6:0] pay_total,
  output logic [6:0] change,
  output logic       dispense_en,
  output logic       insufficient,
  output logic       err_overflow,
  output logic [1:0] state
);
`ifdef VEND_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int CNT_A   = (DISPENSE_CYCLES > HOLD_CYCLES) ? DISPENSE_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX = (TIMEOUT_EN && (TIMEOUT_CYCLES > CNT_A)) ? TIMEOUT_CYCLES : CNT_A;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DISP_LAST = CW'(DISPENSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'b00, S_SELECT = 2'b01, S_DISPENSE = 2'b10, S_DONE = 2'b11;
  localparam logic [2:0] C_NONE = 3'd0, C_ITEM1 = 3'd1, C_ITEM2 = 3'd2, C_ITEM3 = 3'd3,
                         C_ITEM4 = 3'd4, C_CLEAR = 3'd5, C_CONFIRM = 3'd6;
  localparam logic [7:0] MAX8 = 8'(MAX_TOTAL);
  localparam logic [6:0] MAX7 = 7'(MAX_TOTAL);

  logic [1:0]    r_state, w_next;
  logic [2:0]    r_pend;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_item, r_pay, r_change;
  logic          r_insufficient, r_ovf;
  logic [2:0]    w_voice, w_ir, w_pend, w_cmd, w_pend_next;
  logic          w_active, w_is_item, w_coin, w_item_ovf, w_pay_ovf, w_confirm_ok, w_timeout;
  logic [7:0]    w_price, w_coin_sum, w_item_sum, w_pay_sum;
  logic [6:0]    w_item_next, w_pay_next;

  always_comb begin
    w_voice = C_NONE;
    if (voice_valid) begin
      case (voice_cmd)
        3'b001:  w_voice = C_ITEM1;
        3'b010:  w_voice = C_ITEM2;
        3'b100:  w_voice = C_ITEM3;
        3'b011:  w_voice = C_ITEM4;
        3'b000:  w_voice = C_CLEAR;
        3'b110:  w_voice = C_CONFIRM;
        default: w_voice = C_NONE;
      endcase
    end
    w_ir = C_NONE;
    if (ir_valid) begin
      case (ir_cmd)
        8'h01:   w_ir = C_ITEM1;
        8'h02:   w_ir = C_ITEM2;
        8'h03:   w_ir = C_ITEM3;
        8'h04:   w_ir = C_ITEM4;
        8'h0F:   w_ir = C_CONFIRM;
        8'hFF:   w_ir = C_CLEAR;
        default: w_ir = C_NONE;
      endcase
    end
  end

  // A fresh IR strobe replaces whatever sits in the slot; voice always wins the execute port.
  assign w_active    = ~r_state[1];
  assign w_pend      = (w_ir != C_NONE) ? w_ir : r_pend;
  assign w_cmd       = !w_active ? C_NONE : ((w_voice != C_NONE) ? w_voice : w_pend);
  assign w_pend_next = (w_active && (w_voice != C_NONE)) ? w_pend : C_NONE;
  assign w_is_item   = (w_cmd >= C_ITEM1) && (w_cmd <= C_ITEM4);
  assign w_coin      = w_active && (coin_pulse != 3'b000);

  always_comb begin
    case (w_cmd)
      C_ITEM1: w_price = 8'd3;
      C_ITEM2: w_price = 8'd5;
      C_ITEM3: w_price = 8'd8;
      C_ITEM4: w_price = 8'd10;
      default: w_price = 8'd0;
    endcase
  end

  assign w_coin_sum   = (coin_pulse[2] ? 8'd5 : 8'd0) + (coin_pulse[1] ? 8'd1 : 8'd0)
                      + (coin_pulse[0] ? 8'd10 : 8'd0);
  assign w_item_sum   = {1'b0, r_item} + w_price;
  assign w_item_ovf   = w_item_sum > MAX8;
  assign w_item_next  = w_item_ovf ? MAX7 : w_item_sum[6:0];
  assign w_pay_sum    = {1'b0, r_pay} + (w_coin ? w_coin_sum : 8'd0);
  assign w_pay_ovf    = w_pay_sum > MAX8;
  assign w_pay_next   = w_pay_ovf ? MAX7 : w_pay_sum[6:0];
  // Confirm sees this cycle's coins already credited.
  assign w_confirm_ok = (r_item != 7'd0) && (w_pay_next >= r_item);

`ifdef VEND_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic w_sel_event;
  assign w_sel_event = w_coin || (w_cmd != C_NONE);
  assign w_timeout   = (r_state == S_SELECT) && !w_sel_event && (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_is_item || w_coin) w_next = S_SELECT;
      S_SELECT:   if ((w_cmd == C_CONFIRM) && w_confirm_ok) w_next = S_DISPENSE;
                  else if (w_timeout) w_next = S_DONE;
      S_DISPENSE: if (r_cnt == DISP_LAST) w_next = S_DONE;
      default:    if (r_cnt == HOLD_LAST) w_next = S_IDLE;
    endcase
  end

  always_comb begin
    state        = r_state;
    dispense_en  = (r_state == S_DISPENSE);
    item_total   = r_item;
    pay_total    = r_pay;
    change       = r_change;
    insufficient = r_insufficient;
    err_overflow = r_ovf;
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      r_pend         <= C_NONE;
      r_cnt          <= '0;
      r_item         <= 7'd0;
      r_pay          <= 7'd0;
      r_change       <= 7'd0;
      r_insufficient <= 1'b0;
      r_ovf          <= 1'b0;
    end else begin
      r_insufficient <= 1'b0;
      r_pend         <= w_pend_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == S_IDLE) r_cnt <= '0;
`ifdef VEND_TIMEOUT_EN
      else if (r_state == S_SELECT) r_cnt <= w_sel_event ? '0 : r_cnt + 1'b1;
`else
      else if (r_state == S_SELECT) r_cnt <= '0;
`endif
      else r_cnt <= r_cnt + 1'b1;

      if (w_active) begin
        if (w_is_item) r_item <= w_item_next;
        if ((w_cmd == C_CLEAR) && (r_state == S_SELECT)) r_item <= 7'd0;
        if (w_coin) r_pay <= w_pay_next;
        if ((w_is_item && w_item_ovf) || (w_coin && w_pay_ovf)) r_ovf <= 1'b1;
        if ((r_state == S_SELECT) && (w_cmd == C_CONFIRM) && (r_item != 7'd0)) begin
          if (w_confirm_ok) r_change <= w_pay_next - r_item;
          else              r_insufficient <= 1'b1;
        end
        if (w_timeout) begin
          r_change <= r_pay;
          r_item   <= 7'd0;
        end
      end else if ((r_state == S_DONE) && (w_next == S_IDLE)) begin
        r_item   <= 7'd0;
        r_pay    <= 7'd0;
        r_change <= 7'd0;
        r_ovf    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed and randomized self-checking bench for vend_sequencer
// Compares every output each cycle against a transaction-level reference model.
module tb_vend_sequencer;
  localparam int D = 12, H = 7, T = 30, MAXT = 99;

  logic       clock = 1'b0;
  logic       clr_n = 1'b0;
  logic       voice_valid = 1'b0;
  logic [2:0] voice_cmd = 3'd0;
  logic       ir_valid = 1'b0;
  logic [7:0] ir_cmd = 8'h00;
  logic [2:0] coin_pulse = 3'd0;
  logic [6:0] item_total, pay_total, change;
  logic       dispense_en, insufficient, err_overflow;
  logic [1:0] state;

  int checks = 0, failures = 0;
  int m_st, m_item, m_pay, m_change, m_ovf, m_ins, m_pend, m_left, m_idle;

  vend_sequencer #(.DISPENSE_CYCLES(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .MAX_TOTAL(MAXT)) dut (
    .clock(clock), .clr_n(clr_n),
    .voice_valid(voice_valid), .voice_cmd(voice_cmd),
    .ir_valid(ir_valid), .ir_cmd(ir_cmd), .coin_pulse(coin_pulse),
    .item_total(item_total), .pay_total(pay_total), .change(change),
    .dispense_en(dispense_en), .insufficient(insufficient),
    .err_overflow(err_overflow), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Commands: 1-4 items, 5 clear, 6 confirm, 0 nothing.
  function automatic int vdec(input logic [2:0] c);
    case (c)
      3'b001: return 1;
      3'b010: return 2;
      3'b100: return 3;
      3'b011: return 4;
      3'b000: return 5;
      3'b110: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int idec(input logic [7:0] c);
    case (c)
      8'h01: return 1;
      8'h02: return 2;
      8'h03: return 3;
      8'h04: return 4;
      8'hFF: return 5;
      8'h0F: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int price(input int c);
    case (c)
      1: return 3;
      2: return 5;
      3: return 8;
      4: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int sat_add(input int a, input int b);
    if (a + b > MAXT) begin
      m_ovf = 1;
      return MAXT;
    end
    return a + b;
  endfunction

  task automatic model_reset();
    m_st = 0; m_item = 0; m_pay = 0; m_change = 0; m_ovf = 0;
    m_ins = 0; m_pend = 0; m_left = 0; m_idle = 0;
  endtask

  task automatic model_edge(input logic vv, input logic [2:0] vc, input logic iv,
                            input logic [7:0] ic, input logic [2:0] cp);
    int v, i, p, cmd, coin;
    bit ev;
    v = vv ? vdec(vc) : 0;
    i = iv ? idec(ic) : 0;
    p = (i != 0) ? i : m_pend;
    coin = (cp[2] ? 5 : 0) + (cp[1] ? 1 : 0) + (cp[0] ? 10 : 0);
    m_ins = 0;
    if (m_st <= 1) begin
      cmd = (v != 0) ? v : p;
      m_pend = (v != 0) ? p : 0;
      ev = (coin > 0) || (cmd != 0);
      if (cmd >= 1 && cmd <= 4) m_item = sat_add(m_item, price(cmd));
      if (coin > 0) m_pay = sat_add(m_pay, coin);
      if (m_st == 0) begin
        if ((cmd >= 1 && cmd <= 4) || coin > 0) begin
          m_st = 1;
          m_idle = 0;
        end
      end else begin
        if (cmd == 5) m_item = 0;
        if (cmd == 6 && m_item != 0) begin
          if (m_pay < m_item) m_ins = 1;
          else begin
            m_change = m_pay - m_item;
            m_st = 2;
            m_left = D;
          end
        end
`ifdef VEND_TIMEOUT_EN
        if (m_st == 1) begin
          if (ev) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == T) begin
              m_change = m_pay;
              m_item = 0;
              m_st = 3;
              m_left = H;
            end
          end
        end
`endif
      end
    end else begin
      m_pend = 0;
      m_left--;
      if (m_left == 0) begin
        if (m_st == 2) begin
          m_st = 3;
          m_left = H;
        end else begin
          m_st = 0;
          m_item = 0; m_pay = 0; m_change = 0; m_ovf = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_st);
    chk("item_total", 32'(item_total), m_item);
    chk("pay_total", 32'(pay_total), m_pay);
    chk("change", 32'(change), m_change);
    chk("dispense_en", 32'(dispense_en), 32'(m_st == 2));
    chk("insufficient", 32'(insufficient), m_ins);
    chk("err_overflow", 32'(err_overflow), m_ovf);
  endtask

  task automatic step(input logic vv, input logic [2:0] vc, input logic iv,
                      input logic [7:0] ic, input logic [2:0] cp);
    voice_valid = vv; voice_cmd = vc; ir_valid = iv; ir_cmd = ic; coin_pulse = cp;
    @(posedge clock);
    model_edge(vv, vc, iv, ic, cp);
    #1;
    check_all();
  endtask

  task automatic idle();                       step(1'b0, 3'd0, 1'b0, 8'h00, 3'd0); endtask
  task automatic coin(input logic [2:0] cp);   step(1'b0, 3'd0, 1'b0, 8'h00, cp);   endtask
  task automatic voice(input logic [2:0] vc);  step(1'b1, vc, 1'b0, 8'h00, 3'd0);   endtask
  task automatic ir(input logic [7:0] ic);     step(1'b0, 3'd0, 1'b1, ic, 3'd0);    endtask

  task automatic do_reset();
    voice_valid = 1'b0; ir_valid = 1'b0; coin_pulse = 3'd0;
    clr_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int g;
    g = 0;
    while (state != s && g < budget) begin
      idle();
      g++;
    end
    chk("wait_state", 32'(state), 32'(s));
  endtask

  initial begin
    int n, g;
    bit seen;
    logic [7:0] ir_tab [8];

    do_reset();

    // Pay 8 with 1+1+1+5, buy item2, expect change 3 and a D-cycle dispense.
    coin(3'b010); coin(3'b010); coin(3'b010); coin(3'b100);
    chk("t1_pay", 32'(pay_total), 8);
    voice(3'b010);
    chk("t1_item", 32'(item_total), 5);
    voice(3'b110);
    chk("t1_change", 32'(change), 3);
    n = dispense_en ? 1 : 0;
    g = 0;
    while (state == 2'b10 && g < 200) begin
      idle();
      if (dispense_en) n++;
      g++;
    end
    chk("t1_dispense_cycles", n, D);
    chk("t1_done", 32'(state), 3);
    wait_state(2'b00, 50);
    chk("t1_idle_item", 32'(item_total), 0);
    chk("t1_idle_change", 32'(change), 0);

    // Same-cycle voice+IR arbitration and pending-slot overwrite.
    do_reset();
    step(1'b1, 3'b001, 1'b1, 8'h04, 3'd0);
    chk("t2_voice_first", 32'(item_total), 3);
    idle();
    chk("t2_pending_next", 32'(item_total), 13);
    voice(3'b000);
    chk("t2_clear", 32'(item_total), 0);
    step(1'b1, 3'b001, 1'b1, 8'h04, 3'd0);
    ir(8'h02);
    chk("t2_overwrite", 32'(item_total), 8);
    idle();
    chk("t2_slot_empty", 32'(item_total), 8);

    // Insufficient payment.
    do_reset();
    coin(3'b100);
    ir(8'h03);
    ir(8'h0F);
    chk("t3_insufficient", 32'(insufficient), 1);
    chk("t3_state", 32'(state), 1);
    chk("t3_dispense", 32'(dispense_en), 0);
    idle();
    chk("t3_pulse_end", 32'(insufficient), 0);

    // Saturation and overflow flag lifetime.
    do_reset();
    for (int k = 0; k < 10; k++) coin(3'b001);
    chk("t4_pay_sat", 32'(pay_total), 99);
    chk("t4_ovf", 32'(err_overflow), 1);
    voice(3'b001);
    voice(3'b110);
    chk("t4_change", 32'(change), 96);
    wait_state(2'b00, D + H + 10);
    chk("t4_ovf_clr", 32'(err_overflow), 0);

    // Asynchronous reset in the middle of a dispense.
    do_reset();
    coin(3'b100);
    voice(3'b001);
    voice(3'b110);
    for (int k = 0; k < 5; k++) idle();
    chk("t5_dispensing", 32'(dispense_en), 1);
    do_reset();
    chk("t5_state_after", 32'(state), 0);

    // Inactivity in SELECT with pay 6.
    do_reset();
    coin(3'b110);
    chk("t6_pay", 32'(pay_total), 6);
    seen = 1'b0;
    for (int k = 0; k < T; k++) begin
      idle();
      if (dispense_en) seen = 1'b1;
    end
`ifdef VEND_TIMEOUT_EN
    chk("t6_state", 32'(state), 3);
    chk("t6_refund", 32'(change), 6);
    chk("t6_item", 32'(item_total), 0);
    wait_state(2'b00, H + 5);
`else
    for (int k = 0; k < 5; k++) idle();
    chk("t6_state", 32'(state), 1);
    chk("t6_change", 32'(change), 0);
`endif
    chk("t6_no_dispense", 32'(seen), 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic vv, iv;
      logic [2:0] vc, cp;
      logic [7:0] ic;
      ir_tab[0] = 8'h01; ir_tab[1] = 8'h02; ir_tab[2] = 8'h03; ir_tab[3] = 8'h04;
      ir_tab[4] = 8'h0F; ir_tab[5] = 8'hFF; ir_tab[6] = 8'($urandom); ir_tab[7] = 8'h00;
      vv = ($urandom_range(0, 5) == 0);
      vc = 3'($urandom_range(0, 7));
      iv = ($urandom_range(0, 5) == 0);
      ic = ir_tab[$urandom_range(0, 7)];
      cp = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(vv, vc, iv, ic, cp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
